esm_multi_issue_core: RTL and testbench

- Parametrised successor of the single-index ESM core: an instruction window of BS entries with integrated register-dependency analysis.
- Selects and issues up to ISSUE_W mutually independent instructions per cycle, oldest first.
- Sits between fetch/decode and the execution lanes.
- Replaces the single next_buffer_index/valid_count interface with per-lane valid/instruction/index outputs and an enqueue handshake.

---
 rtl/esm_multi_issue_core.sv | 131 +++++++++++++
 tb/tb_esm_multi_issue_core.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/esm_multi_issue_core.sv
// esm_multi_issue_core: BS-entry instruction window that issues up to ISSUE_W independent instructions per cycle, oldest first.
// Define ESM_WAR_CHECK_EN to also block an entry on WAR hazards against older entries.
module esm_multi_issue_core #(
    parameter int IW      = 32,
    parameter int BS      = 16,
    parameter int REGNUM  = 32,
    parameter int ISSUE_W = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [IW-1:0]                 instr_in,
    input  logic                          reg_write,
    input  logic                          alu_src,
    input  logic                          issue_ready,
    output logic [ISSUE_W-1:0]            issue_valid,
    output logic [ISSUE_W*IW-1:0]         issue_instr,
    output logic [ISSUE_W*$clog2(BS)-1:0] issue_idx,
    output logic [$clog2(BS):0]           occupancy
);
    localparam int AW = $clog2(BS);
    localparam int RW = $clog2(REGNUM);

    logic [BS-1:0] r_valid, r_wr, r_rs2u;
    logic [IW-1:0] r_instr [BS];
    logic [RW-1:0] r_rd [BS];
    logic [RW-1:0] r_rs1 [BS];
    logic [RW-1:0] r_rs2 [BS];
    logic [AW-1:0] r_head, r_tail;
    logic [AW:0]   r_cnt;

    logic [BS-1:0] w_blocked, w_clr, w_vnext;
    logic [AW-1:0] w_j, w_o, w_s;
    logic [AW:0]   w_adv;
    logic          w_stop, w_found, w_enq;

    assign in_ready = !r_cnt[AW] && !flush;
    assign w_enq    = in_valid && in_ready;

    // Entry j is blocked by any valid entry older than it in ring order.
    always_comb begin
        w_blocked = '0;
        w_j = '0;
        w_o = '0;
        for (int a = 1; a < BS; a++) begin
            w_j = r_head + AW'(a);
            for (int b = 0; b < a; b++) begin
                w_o = r_head + AW'(b);
                if (r_valid[w_o] && r_wr[w_o] && (r_rd[w_o] == r_rs1[w_j] ||
                    (r_rs2u[w_j] && r_rd[w_o] == r_rs2[w_j]) ||
                    (r_wr[w_j] && r_rd[w_o] == r_rd[w_j])))
                    w_blocked[w_j] = 1'b1;
`ifdef ESM_WAR_CHECK_EN
                if (r_valid[w_o] && r_wr[w_j] && (r_rs1[w_o] == r_rd[w_j] ||
                    (r_rs2u[w_o] && r_rs2[w_o] == r_rd[w_j])))
                    w_blocked[w_j] = 1'b1;
`endif
            end
        end
    end

    always_comb begin
        issue_valid = '0;
        issue_instr = '0;
        issue_idx   = '0;
        w_clr       = '0;
        w_s         = '0;
        w_found     = 1'b0;
        for (int l = 0; l < ISSUE_W; l++) begin
            w_found = 1'b0;
            for (int a = 0; a < BS; a++) begin
                w_s = r_head + AW'(a);
                if (!w_found && r_valid[w_s] && !w_blocked[w_s] && !w_clr[w_s]) begin
                    issue_valid[l]           = 1'b1;
                    issue_instr[l*IW +: IW]  = r_instr[w_s];
                    issue_idx[l*AW +: AW]    = w_s;
                    w_clr[w_s]               = 1'b1;
                    w_found                  = 1'b1;
                end
            end
        end
    end

    // Head skips the run of invalid slots it now points at, never past the pre-edge tail.
    always_comb begin
        w_vnext = r_valid & ~({BS{issue_ready}} & w_clr);
        w_adv   = '0;
        w_stop  = 1'b0;
        for (int a = 0; a < BS; a++) begin
            if (!w_stop && a < int'(r_cnt) && !w_vnext[r_head + AW'(a)])
                w_adv = w_adv + (AW+1)'(1);
            else
                w_stop = 1'b1;
        end
        occupancy = '0;
        for (int a = 0; a < BS; a++)
            occupancy = occupancy + (AW+1)'(r_valid[a]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_cnt   <= '0;
        end else if (flush) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_cnt   <= '0;
        end else begin
            r_valid <= w_vnext | ({BS{w_enq}} & (BS'(1) << r_tail));
            r_head  <= r_head + w_adv[AW-1:0];
            r_tail  <= r_tail + AW'(w_enq);
            r_cnt   <= r_cnt - w_adv + (AW+1)'(w_enq);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_instr[r_tail] <= instr_in;
            r_rd[r_tail]    <= instr_in[7 +: RW];
            r_rs1[r_tail]   <= instr_in[15 +: RW];
            r_rs2[r_tail]   <= instr_in[20 +: RW];
            r_wr[r_tail]    <= reg_write && instr_in[7 +: RW] != '0;
            r_rs2u[r_tail]  <= !alu_src;
        end
    end
endmodule

// File: tb/tb_esm_multi_issue_core.sv
// tb_esm_multi_issue_core: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based model of the instruction window.
module tb_esm_multi_issue_core;
    localparam int IW = 32, BS = 16, REGNUM = 32, ISSUE_W = 2, AW = 4;

    logic clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, reg_write = 1'b0;
    logic alu_src = 1'b0, issue_ready = 1'b0, in_ready;
    logic [IW-1:0] instr_in = '0;
    logic [ISSUE_W-1:0] issue_valid;
    logic [ISSUE_W*IW-1:0] issue_instr;
    logic [ISSUE_W*AW-1:0] issue_idx;
    logic [AW:0] occupancy;

    int n_chk = 0, n_err = 0;

    esm_multi_issue_core #(.IW(IW), .BS(BS), .REGNUM(REGNUM), .ISSUE_W(ISSUE_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr_in(instr_in), .reg_write(reg_write), .alu_src(alu_src),
        .issue_ready(issue_ready), .issue_valid(issue_valid), .issue_instr(issue_instr),
        .issue_idx(issue_idx), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int slot;
        logic [31:0] ins;
        int rd;
        int rs1;
        int rs2;
        bit wr;
        bit u;
        bit v;
    } ent_t;

    ent_t q[$];
    int   m_head;
    int   sel[$];

    typedef struct {
        bit fl, iv;
        logic [31:0] ins;
        bit rw, as, ir;
        logic [1:0] ev;
        int i0, i1, occ;
        bit rdy;
    } vec_t;

    vec_t tv[27];

    function automatic logic [31:0] rt(int rd, int rs1, int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] sb(int rd, int rs1, int rs2);
        return {7'h20, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] it(int rd, int rs1, int imm);
        return {7'd0, 5'(imm), 5'(rs1), 3'd0, 5'(rd), 7'h13};
    endfunction

    function automatic vec_t mk(bit fl, bit iv, logic [31:0] ins, bit rw, bit as, bit ir,
                                logic [1:0] ev, int i0, int i1, int occ, bit rdy);
        vec_t r;
        r.fl = fl; r.iv = iv; r.ins = ins; r.rw = rw; r.as = as; r.ir = ir;
        r.ev = ev; r.i0 = i0; r.i1 = i1; r.occ = occ; r.rdy = rdy;
        return r;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit hz(ent_t o, ent_t y);
        bit war;
        war = 1'b0;
`ifdef ESM_WAR_CHECK_EN
        war = y.wr && (o.rs1 == y.rd || (o.u && o.rs2 == y.rd));
`endif
        return (o.wr && (o.rd == y.rs1 || (y.u && o.rd == y.rs2))) ||
               (o.wr && y.wr && o.rd == y.rd) || war;
    endfunction

    task automatic compute_sel();
        bit blk;
        sel.delete();
        for (int i = 0; i < q.size(); i++) begin
            blk = 1'b0;
            if (q[i].v) begin
                for (int k = 0; k < i; k++)
                    if (q[k].v && hz(q[k], q[i])) blk = 1'b1;
                if (!blk && sel.size() < ISSUE_W) sel.push_back(i);
            end
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_head = 0;
    endtask

    task automatic model_update();
        bit rdy;
        int slot;
        ent_t e;
        if (flush) begin
            model_reset();
            return;
        end
        rdy = q.size() < BS;
        compute_sel();
        if (issue_ready) foreach (sel[k]) q[sel[k]].v = 1'b0;
        slot = (m_head + q.size()) % BS;
        while (q.size() > 0 && !q[0].v) begin
            void'(q.pop_front());
            m_head = (m_head + 1) % BS;
        end
        if (in_valid && rdy) begin
            e.slot = slot; e.ins = instr_in;
            e.rd = int'(instr_in[11:7]); e.rs1 = int'(instr_in[19:15]); e.rs2 = int'(instr_in[24:20]);
            e.wr = reg_write && e.rd != 0; e.u = !alu_src; e.v = 1'b1;
            q.push_back(e);
        end
    endtask

    task automatic check_model();
        int occ;
        occ = 0;
        compute_sel();
        foreach (q[i]) occ += int'(q[i].v);
        for (int l = 0; l < ISSUE_W; l++) begin
            chk($sformatf("m_lane%0d_valid", l), 64'(issue_valid[l]), 64'(l < sel.size()));
            if (l < sel.size()) begin
                chk($sformatf("m_lane%0d_instr", l), 64'(issue_instr[l*IW +: IW]), 64'(q[sel[l]].ins));
                chk($sformatf("m_lane%0d_idx", l), 64'(issue_idx[l*AW +: AW]), 64'(q[sel[l]].slot));
            end
        end
        chk("m_occupancy", 64'(occupancy), 64'(occ));
        chk("m_in_ready", 64'(in_ready), 64'(q.size() < BS && !flush));
    endtask

    task automatic drive(bit fl, bit iv, logic [31:0] ins, bit rw, bit as, bit ir);
        flush = fl; in_valid = iv; instr_in = ins; reg_write = rw; alu_src = as; issue_ready = ir;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic step(bit fl, bit iv, logic [31:0] ins, bit rw, bit as, bit ir);
        drive(fl, iv, ins, rw, as, ir);
        check_model();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(0, 0, '0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int thr;
        logic [31:0] ins;
        tv[0]  = mk(0, 1, rt(1, 2, 3), 1, 0, 0, 2'b00, 0, 0, 0, 1);
        tv[1]  = mk(0, 1, rt(4, 5, 6), 1, 0, 0, 2'b01, 0, 0, 1, 1);
        tv[2]  = mk(0, 0, '0,          0, 0, 0, 2'b11, 0, 1, 2, 1);
        tv[3]  = mk(0, 0, '0,          0, 0, 1, 2'b11, 0, 1, 2, 1);
        tv[4]  = mk(0, 0, '0,          0, 0, 0, 2'b00, 0, 0, 0, 1);
        tv[5]  = mk(0, 1, rt(1, 2, 3), 1, 0, 0, 2'b00, 0, 0, 0, 1);
        tv[6]  = mk(0, 1, sb(7, 1, 4), 1, 0, 0, 2'b01, 2, 0, 1, 1);
        tv[7]  = mk(0, 0, '0,          0, 0, 1, 2'b01, 2, 0, 2, 1);
        tv[8]  = mk(0, 0, '0,          0, 0, 1, 2'b01, 3, 0, 1, 1);
        tv[9]  = mk(0, 0, '0,          0, 0, 0, 2'b00, 0, 0, 0, 1);
        tv[10] = mk(0, 1, it(5, 0, 5), 1, 1, 0, 2'b00, 0, 0, 0, 1);
        tv[11] = mk(0, 1, rt(5, 6, 7), 1, 0, 0, 2'b01, 4, 0, 1, 1);
        tv[12] = mk(0, 1, rt(8, 5, 9), 1, 0, 0, 2'b01, 4, 0, 2, 1);
        tv[13] = mk(0, 0, '0,          0, 0, 0, 2'b01, 4, 0, 3, 1);
        tv[14] = mk(0, 0, '0,          0, 0, 1, 2'b01, 4, 0, 3, 1);
        tv[15] = mk(0, 0, '0,          0, 0, 1, 2'b01, 5, 0, 2, 1);
        tv[16] = mk(0, 0, '0,          0, 0, 1, 2'b01, 6, 0, 1, 1);
        tv[17] = mk(0, 0, '0,          0, 0, 0, 2'b00, 0, 0, 0, 1);
        tv[18] = mk(0, 1, sb(3, 1, 2), 1, 0, 0, 2'b00, 0, 0, 0, 1);
        tv[19] = mk(0, 1, rt(1, 4, 5), 1, 0, 0, 2'b01, 7, 0, 1, 1);
`ifdef ESM_WAR_CHECK_EN
        tv[20] = mk(0, 0, '0,          0, 0, 0, 2'b01, 7, 0, 2, 1);
        tv[21] = mk(0, 0, '0,          0, 0, 1, 2'b01, 7, 0, 2, 1);
        tv[22] = mk(0, 0, '0,          0, 0, 0, 2'b01, 8, 0, 1, 1);
        tv[23] = mk(0, 0, '0,          0, 0, 1, 2'b01, 8, 0, 1, 1);
`else
        tv[20] = mk(0, 0, '0,          0, 0, 0, 2'b11, 7, 8, 2, 1);
        tv[21] = mk(0, 0, '0,          0, 0, 1, 2'b11, 7, 8, 2, 1);
        tv[22] = mk(0, 0, '0,          0, 0, 0, 2'b00, 0, 0, 0, 1);
        tv[23] = mk(0, 0, '0,          0, 0, 1, 2'b00, 0, 0, 0, 1);
`endif
        tv[24] = mk(0, 0, '0,          0, 0, 0, 2'b00, 0, 0, 0, 1);
        tv[25] = mk(1, 1, rt(9, 9, 9), 1, 0, 1, 2'b00, 0, 0, 0, 0);
        tv[26] = mk(0, 0, '0,          0, 0, 0, 2'b00, 0, 0, 0, 1);

        do_reset();
        foreach (tv[i]) begin
            drive(tv[i].fl, tv[i].iv, tv[i].ins, tv[i].rw, tv[i].as, tv[i].ir);
            chk($sformatf("t%0d_valid", i), 64'(issue_valid), 64'(tv[i].ev));
            if (tv[i].ev[0]) chk($sformatf("t%0d_idx0", i), 64'(issue_idx[AW-1:0]), 64'(tv[i].i0));
            if (tv[i].ev[1]) chk($sformatf("t%0d_idx1", i), 64'(issue_idx[2*AW-1:AW]), 64'(tv[i].i1));
            chk($sformatf("t%0d_occ", i), 64'(occupancy), 64'(tv[i].occ));
            chk($sformatf("t%0d_ready", i), 64'(in_ready), 64'(tv[i].rdy));
            tick();
        end

        // Fill the window, then leave a hole behind a valid head.
        do_reset();
        for (int k = 0; k < BS; k++)
            step(0, 1, k == 0 ? rt(1, 2, 3) : k == 1 ? rt(10, 1, 0) : rt(16 + k, 2, 3), 1, 0, 0);
        drive(0, 1, rt(20, 2, 3), 1, 0, 0);
        chk("full_ready", 64'(in_ready), 64'(0));
        chk("full_occ", 64'(occupancy), 64'(16));
        check_model();
        tick();
        drive(0, 0, '0, 0, 0, 1);
        chk("full_ignore_occ", 64'(occupancy), 64'(16));
        check_model();
        tick();
        step(0, 1, rt(15, 2, 3), 1, 0, 0);
        drive(0, 0, '0, 0, 0, 0);
        chk("hole_occ", 64'(occupancy), 64'(15));
        chk("hole_ready", 64'(in_ready), 64'(0));
        check_model();
        tick();
        step(0, 0, '0, 0, 0, 1);
        drive(0, 0, '0, 0, 0, 0);
        chk("hole_reclaim_ready", 64'(in_ready), 64'(1));
        check_model();
        tick();

        // Flush a half-full window while enqueue and issue are both requested.
        do_reset();
        for (int k = 0; k < 8; k++) step(0, 1, rt(k + 1, 20, 21), 1, 0, 0);
        drive(1, 1, rt(30, 1, 2), 1, 0, 1);
        chk("flush_ready", 64'(in_ready), 64'(0));
        check_model();
        tick();
        drive(0, 0, '0, 0, 0, 0);
        chk("flush_occ", 64'(occupancy), 64'(0));
        chk("flush_valid", 64'(issue_valid), 64'(0));
        check_model();
        tick();

        // Asynchronous reset pulse in the middle of a cycle.
        for (int k = 0; k < 3; k++) step(0, 1, rt(k + 1, 20, 21), 1, 0, 0);
        drive(0, 0, '0, 0, 0, 0);
        chk("pre_arst_occ", 64'(occupancy), 64'(3));
        #1 rst = 1'b0;
        #1;
        chk("arst_occ", 64'(occupancy), 64'(0));
        chk("arst_valid", 64'(issue_valid), 64'(0));
        chk("arst_ready", 64'(in_ready), 64'(1));
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        thr = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) thr = (c / 200) % 3 == 0 ? 20 : (c / 200) % 3 == 1 ? 50 : 90;
            ins = $urandom;
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 70, ins,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 99) < thr);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
